fft_frame_sequencer: RTL and testbench
======================================

// Module: fft_frame_sequencer
// PURPOSE
//  Host-side controller for fft_pipeline. Streams samples in, writes each frame into the core's
//  input RAM at bit-reversed addresses, pulses start, waits for fft_done, then reads bins in
//  natural order and streams them out with squared magnitude. Sits between sample source and sink.
// PARAMETERS
//  N        32    points per frame (power of 2)
//  LOG2N    5     address width, log2(N)
//  DW       32    sample width; [DW-1:DW/2] = re, [DW/2-1:0] = im, both signed
//  RD_LAT   2     cycles from addr_rd change to valid o_data (>=1)
//  TIMEOUT  4096  max cycles from start to fft_done
// PORTS
//  clk        in   1      clock, all logic on posedge
//  reset      in   1      asynchronous, active-high
//  s_valid    in   1      input sample valid
//  s_ready    out  1      sequencer accepts sample
//  s_data     in   DW     input sample {re,im}
//  load       out  1      core RAM write enable
//  addr_wr    out  LOG2N  core write address (bit-reversed sample index)
//  in_data    out  DW     core write data
//  start      out  1      one-cycle FFT start pulse
//  fft_done   in   1      core completion level
//  addr_rd    out  LOG2N  core read address
//  o_data     in   DW     core read data {re,im}
//  m_valid    out  1      output bin valid
//  m_ready    in   1      sink accepts bin
//  m_data     out  DW     bin {re,im}
//  m_mag2     out  DW     re*re + im*im, unsigned
//  m_index    out  LOG2N  bin index k
//  m_last     out  1      high with k == N-1
//  busy       out  1      high in every state except LOAD
//  err_tmo    out  1      sticky timeout flag, cleared only by reset
// BEHAVIOUR
//  Reset: state LOAD; cnt=0; s_ready=1; load, start, m_valid, m_last, err_tmo=0.
//   All address, data, m_* buses 0. Reset mid-frame discards the frame; nothing is flushed.
//  All core-side and m_* outputs are registered.
//  LOAD: s_ready=1. On s_valid&s_ready, next cycle load=1, addr_wr=bitrev(cnt), in_data=s_data.
//   cnt increments. Gaps in s_valid give load=0. The Nth accept sets s_ready=0 at once.
//   The Nth accept goes to START after that write cycle.
//  START: start=1 for exactly one cycle; tmo counter cleared -> WAIT_DONE.
//  WAIT_DONE: done_q registers fft_done every cycle. Advance only on rising edge
//   (fft_done & ~done_q) seen in this state; a level left high from the previous frame is ignored.
//   Counter reaching TIMEOUT: err_tmo=1, cnt=0 -> LOAD. The frame is dropped.
//  READ_ADDR: addr_rd=k (natural order) -> READ_WAIT.
//  READ_WAIT: wait RD_LAT cycles, then capture o_data into m_data.
//   Capture m_mag2 = $signed(re)^2 + $signed(im)^2 (sum of two 2*(DW/2)-bit products, kept DW bits).
//   Set m_index=k, m_last=(k==N-1), m_valid=1 -> OUT.
//  OUT: hold all m_* stable while m_valid & ~m_ready.
//   On handshake: m_valid=0; k==N-1 -> LOAD (cnt=0, s_ready=1), else k++ -> READ_ADDR.
//  Throughput per bin: RD_LAT+2 cycles min. No sample accepted outside LOAD.
//  Boundaries: m_ready held high gives back-to-back bins without stalls beyond the above.
//   m_mag2 for re=im=-32768 (DW=32) = 0x8000_0000, no overflow.
//   fft_done rising in START is missed by design; the core must not finish in 0 cycles.
// STRUCTURE
//  Include fft_defs.vh: N, LOG2N, DW, RE/IM field slices, state encodings
//   (LOAD, START, WAIT_DONE, READ_ADDR, READ_WAIT, OUT).
//  bitrev as a function in fft_defs.vh.
//  One sub-module fft_mag2: registered signed re^2+im^2, enable = capture strobe.
//  Remainder: one FSM + cnt/k, latency and timeout counters.
// TESTING
//  Bench: fft_pipeline model, configurable done delay, RD_LAT-cycle read pipe. N=32.
//  1 Ramp s_data=i<<16, s_valid always 1 -> writes addr_wr 0,16,8,24,...,31.
//    Then one start pulse exactly 1 cycle after 32nd write.
//  2 Impulse {16'd1000,0} at i=0, rest 0, real fft_pipeline -> 32 bins, m_index 0..31.
//    Every m_mag2 = 1_000_000 scaled per core gain; m_last only on 31.
//  3 Random s_valid gaps + m_ready toggling 50% -> no lost/duplicated sample or bin.
//    m_* stable while stalled.
//  4 fft_done stuck high from previous frame, then low, then high after 40 cycles.
//    -> readout begins only after the new edge.
//  5 fft_done never asserts -> err_tmo=1 after TIMEOUT cycles, s_ready=1, next frame processed.
//  6 reset asserted during READ_WAIT at k=7 -> outputs return to reset values immediately.
//    New frame then loads from cnt=0.

Source files
------------

// File: rtl/fft_frame_sequencer_pkg.sv
// ============================================================================
// fft_frame_sequencer_pkg : frame geometry, sample field helpers, FSM states
// Revision : 1.0
// ============================================================================
`default_nettype none

package fft_frame_sequencer_pkg;

    localparam int N     = 32;
    localparam int LOG2N = 5;
    localparam int DW    = 32;
    localparam int HW    = DW / 2;

    typedef enum logic [2:0] {
        ST_LOAD      = 3'd0,
        ST_START     = 3'd1,
        ST_WAIT_DONE = 3'd2,
        ST_READ_ADDR = 3'd3,
        ST_READ_WAIT = 3'd4,
        ST_OUT       = 3'd5
    } state_t;

    // The core expects its input RAM in bit-reversed order so the bins come out natural.
    function automatic logic [LOG2N-1:0] bitrev(input logic [LOG2N-1:0] v);
        logic [LOG2N-1:0] r;
        for (int i = 0; i < LOG2N; i++) begin
            r[i] = v[LOG2N-1-i];
        end
        return r;
    endfunction

    function automatic logic signed [HW-1:0] re_of(input logic [DW-1:0] d);
        return d[DW-1:HW];
    endfunction

    function automatic logic signed [HW-1:0] im_of(input logic [DW-1:0] d);
        return d[HW-1:0];
    endfunction

endpackage

`default_nettype wire

// File: rtl/fft_frame_sequencer_mag2.sv
// ============================================================================
// fft_frame_sequencer_mag2 : registered squared magnitude re^2 + im^2
// Revision : 1.0
// ============================================================================
`default_nettype none

module fft_frame_sequencer_mag2
    import fft_frame_sequencer_pkg::*;
(
    input  logic          clk,
    input  logic          reset,
    input  logic          en,
    input  logic [DW-1:0] data,
    output logic [DW-1:0] mag2
);

    logic signed [HW-1:0] re_v;
    logic signed [HW-1:0] im_v;
    logic signed [DW-1:0] re_x;
    logic signed [DW-1:0] im_x;
    logic signed [DW-1:0] re_sq;
    logic signed [DW-1:0] im_sq;
    logic [DW-1:0]        mag2_d;
    logic [DW-1:0]        mag2_q;

    assign re_v = re_of(data);
    assign im_v = im_of(data);

    // Widen before multiplying; the largest sum (2 * 2^(2*HW-2)) still fits unsigned in DW bits.
    assign re_x  = {{HW{re_v[HW-1]}}, re_v};
    assign im_x  = {{HW{im_v[HW-1]}}, im_v};
    assign re_sq = re_x * re_x;
    assign im_sq = im_x * im_x;

    always_comb begin
        mag2_d = mag2_q;
        if (en) begin
            mag2_d = $unsigned(re_sq) + $unsigned(im_sq);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mag2_q <= '0;
        end else begin
            mag2_q <= mag2_d;
        end
    end

    assign mag2 = mag2_q;

endmodule

`default_nettype wire

// File: rtl/fft_frame_sequencer.sv
// ============================================================================
// fft_frame_sequencer : loads frames into the FFT core bit-reversed, starts it,
//                       waits for done and streams bins out with |X|^2
// Revision : 1.0
// ============================================================================
`default_nettype none

module fft_frame_sequencer
    import fft_frame_sequencer_pkg::*;
#(
    parameter int RD_LAT  = 2,
    parameter int TIMEOUT = 4096
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             s_valid,
    output logic             s_ready,
    input  logic [DW-1:0]    s_data,
    output logic             load,
    output logic [LOG2N-1:0] addr_wr,
    output logic [DW-1:0]    in_data,
    output logic             start,
    input  logic             fft_done,
    output logic [LOG2N-1:0] addr_rd,
    input  logic [DW-1:0]    o_data,
    output logic             m_valid,
    input  logic             m_ready,
    output logic [DW-1:0]    m_data,
    output logic [DW-1:0]    m_mag2,
    output logic [LOG2N-1:0] m_index,
    output logic             m_last,
    output logic             busy,
    output logic             err_tmo
);

    localparam int TW = $clog2(TIMEOUT + 1);
    localparam int LW = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;

    state_t           state_q,   state_d;
    logic [LOG2N-1:0] cnt_q,     cnt_d;
    logic [LOG2N-1:0] k_q,       k_d;
    logic [LW-1:0]    lat_q,     lat_d;
    logic [TW-1:0]    tmo_q,     tmo_d;
    logic             done_q,    done_d;
    logic             s_ready_q, s_ready_d;
    logic             load_q,    load_d;
    logic [LOG2N-1:0] addr_wr_q, addr_wr_d;
    logic [DW-1:0]    in_data_q, in_data_d;
    logic             start_q,   start_d;
    logic [LOG2N-1:0] addr_rd_q, addr_rd_d;
    logic             m_valid_q, m_valid_d;
    logic [DW-1:0]    m_data_q,  m_data_d;
    logic [LOG2N-1:0] m_index_q, m_index_d;
    logic             m_last_q,  m_last_d;
    logic             err_tmo_q, err_tmo_d;

    logic             accept;
    logic             capture;
    logic             done_rise;

    assign accept    = (state_q == ST_LOAD) && s_valid && s_ready_q;
    // A done level carried over from the previous frame never qualifies; only a fresh edge does.
    assign done_rise = (state_q == ST_WAIT_DONE) && fft_done && !done_q;
    assign done_d    = fft_done;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        k_d       = k_q;
        lat_d     = lat_q;
        tmo_d     = tmo_q;
        s_ready_d = s_ready_q;
        load_d    = 1'b0;
        addr_wr_d = addr_wr_q;
        in_data_d = in_data_q;
        start_d   = 1'b0;
        addr_rd_d = addr_rd_q;
        m_valid_d = m_valid_q;
        m_data_d  = m_data_q;
        m_index_d = m_index_q;
        m_last_d  = m_last_q;
        err_tmo_d = err_tmo_q;
        capture   = 1'b0;

        case (state_q)
            ST_LOAD: begin
                if (accept) begin
                    load_d    = 1'b1;
                    addr_wr_d = bitrev(cnt_q);
                    in_data_d = s_data;
                    cnt_d     = cnt_q + 1'b1;
                    if (cnt_q == LOG2N'(N - 1)) begin
                        s_ready_d = 1'b0;
                        state_d   = ST_START;
                    end
                end
            end
            ST_START: begin
                start_d = 1'b1;
                tmo_d   = '0;
                state_d = ST_WAIT_DONE;
            end
            ST_WAIT_DONE: begin
                if (done_rise) begin
                    k_d       = '0;
                    addr_rd_d = '0;
                    state_d   = ST_READ_ADDR;
                end else if (tmo_q == TW'(TIMEOUT - 1)) begin
                    err_tmo_d = 1'b1;
                    cnt_d     = '0;
                    s_ready_d = 1'b1;
                    state_d   = ST_LOAD;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
            end
            ST_READ_ADDR: begin
                lat_d   = '0;
                state_d = ST_READ_WAIT;
            end
            ST_READ_WAIT: begin
                // addr_rd was already stable through READ_ADDR, so RD_LAT wait cycles cover the read pipe.
                if (lat_q == LW'(RD_LAT - 1)) begin
                    capture   = 1'b1;
                    m_data_d  = o_data;
                    m_index_d = k_q;
                    m_last_d  = (k_q == LOG2N'(N - 1));
                    m_valid_d = 1'b1;
                    state_d   = ST_OUT;
                end else begin
                    lat_d = lat_q + 1'b1;
                end
            end
            ST_OUT: begin
                if (m_ready) begin
                    m_valid_d = 1'b0;
                    if (k_q == LOG2N'(N - 1)) begin
                        cnt_d     = '0;
                        s_ready_d = 1'b1;
                        state_d   = ST_LOAD;
                    end else begin
                        k_d       = k_q + 1'b1;
                        addr_rd_d = k_q + 1'b1;
                        state_d   = ST_READ_ADDR;
                    end
                end
            end
            default: begin
                state_d = ST_LOAD;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= ST_LOAD;
            cnt_q     <= '0;
            k_q       <= '0;
            lat_q     <= '0;
            tmo_q     <= '0;
            done_q    <= 1'b0;
            s_ready_q <= 1'b1;
            load_q    <= 1'b0;
            addr_wr_q <= '0;
            in_data_q <= '0;
            start_q   <= 1'b0;
            addr_rd_q <= '0;
            m_valid_q <= 1'b0;
            m_data_q  <= '0;
            m_index_q <= '0;
            m_last_q  <= 1'b0;
            err_tmo_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            k_q       <= k_d;
            lat_q     <= lat_d;
            tmo_q     <= tmo_d;
            done_q    <= done_d;
            s_ready_q <= s_ready_d;
            load_q    <= load_d;
            addr_wr_q <= addr_wr_d;
            in_data_q <= in_data_d;
            start_q   <= start_d;
            addr_rd_q <= addr_rd_d;
            m_valid_q <= m_valid_d;
            m_data_q  <= m_data_d;
            m_index_q <= m_index_d;
            m_last_q  <= m_last_d;
            err_tmo_q <= err_tmo_d;
        end
    end

    fft_frame_sequencer_mag2 u_mag2 (
        .clk   (clk),
        .reset (reset),
        .en    (capture),
        .data  (o_data),
        .mag2  (m_mag2)
    );

    assign s_ready = s_ready_q;
    assign load    = load_q;
    assign addr_wr = addr_wr_q;
    assign in_data = in_data_q;
    assign start   = start_q;
    assign addr_rd = addr_rd_q;
    assign m_valid = m_valid_q;
    assign m_data  = m_data_q;
    assign m_index = m_index_q;
    assign m_last  = m_last_q;
    assign busy    = (state_q != ST_LOAD);
    assign err_tmo = err_tmo_q;

endmodule

`default_nettype wire

// File: tb/tb_fft_frame_sequencer.sv
// ============================================================================
// tb_fft_frame_sequencer : random frames through a RAM-backed core stand-in,
//                          bins scoreboarded against a frame-level model
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_fft_frame_sequencer;
    import fft_frame_sequencer_pkg::*;

    localparam int RD_LAT  = 2;
    localparam int TIMEOUT = 4096;

    logic             clk;
    logic             reset;
    logic             s_valid;
    logic             s_ready;
    logic [DW-1:0]    s_data;
    logic             load;
    logic [LOG2N-1:0] addr_wr;
    logic [DW-1:0]    in_data;
    logic             start;
    logic             fft_done;
    logic [LOG2N-1:0] addr_rd;
    logic [DW-1:0]    o_data;
    logic             m_valid;
    logic             m_ready;
    logic [DW-1:0]    m_data;
    logic [DW-1:0]    m_mag2;
    logic [LOG2N-1:0] m_index;
    logic             m_last;
    logic             busy;
    logic             err_tmo;

    fft_frame_sequencer #(.RD_LAT(RD_LAT), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .reset(reset), .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
        .load(load), .addr_wr(addr_wr), .in_data(in_data), .start(start), .fft_done(fft_done),
        .addr_rd(addr_rd), .o_data(o_data), .m_valid(m_valid), .m_ready(m_ready),
        .m_data(m_data), .m_mag2(m_mag2), .m_index(m_index), .m_last(m_last),
        .busy(busy), .err_tmo(err_tmo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] data;
        logic [31:0] mag;
        int          idx;
        logic        last;
    } bin_t;

    bin_t        exp_q[$];
    logic [31:0] acc_q[$];
    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int done_mode  = 0;
    int done_delay = 10;
    int rdy_mode   = 0;
    bit rise_flag  = 1'b0;
    int wr_idx = 0;
    int last_load_cyc = -10;
    logic [31:0] fr[N];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    task automatic fail(input string nm);
        total++;
        bad++;
        $display("FAIL %s: event not expected / bound expired", nm);
    endtask

    task automatic finish_now();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    endtask

    // Reference bit reversal built from arithmetic on the sample index.
    function automatic int rev_idx(input int i);
        int r = 0;
        int x = i;
        for (int b = 0; b < LOG2N; b++) begin
            r = r * 2 + (x % 2);
            x = x / 2;
        end
        return r;
    endfunction

    function automatic logic [31:0] mag_of(input logic [31:0] d);
        longint re;
        longint im;
        longint s;
        re = longint'($signed(d[31:16]));
        im = longint'($signed(d[15:0]));
        s  = re * re + im * im;
        return s[31:0];
    endfunction

    always @(posedge clk) cyc++;

    // Core stand-in: bins read back exactly what was written at that RAM address.
    logic [DW-1:0] mem  [N];
    logic [DW-1:0] pipe [RD_LAT];
    always @(posedge clk) begin
        if (load) mem[addr_wr] <= in_data;
        pipe[0] <= mem[addr_rd];
        for (int i = 1; i < RD_LAT; i++) pipe[i] <= pipe[i-1];
    end
    assign o_data = pipe[RD_LAT-1];

    initial begin
        fft_done = 1'b0;
        forever begin
            @(negedge clk);
            if (!reset && start) begin
                rise_flag = 1'b0;
                if (done_mode == 0) begin
                    fft_done = 1'b0;
                    repeat (done_delay) @(negedge clk);
                    fft_done  = 1'b1;
                    rise_flag = 1'b1;
                end else if (done_mode == 1) begin
                    fft_done = 1'b1;
                    repeat (5) @(negedge clk);
                    fft_done = 1'b0;
                    repeat (34) @(negedge clk);
                    fft_done  = 1'b1;
                    rise_flag = 1'b1;
                end else begin
                    fft_done = 1'b0;
                end
            end
        end
    end

    // Core-side monitor: write order, write data, start timing; pushes expected bins.
    initial begin
        logic [31:0] s;
        forever begin
            @(negedge clk);
            if (!reset) begin
                if (load) begin
                    if (wr_idx >= N || acc_q.size() == 0) begin
                        fail("extra_write");
                    end else begin
                        s = acc_q.pop_front();
                        chk("addr_wr", 64'(addr_wr), 64'(rev_idx(wr_idx)));
                        chk("in_data", 64'(in_data), 64'(s));
                        fr[wr_idx] = s;
                        wr_idx++;
                        last_load_cyc = cyc;
                    end
                end
                if (start) begin
                    chk("start_after_last_write", 64'(wr_idx == N && last_load_cyc == cyc - 1), 64'd1);
                    if (done_mode != 2) begin
                        for (int k = 0; k < N; k++) begin
                            bin_t b;
                            b.data = fr[rev_idx(k)];
                            b.mag  = mag_of(b.data);
                            b.idx  = k;
                            b.last = (k == N - 1);
                            exp_q.push_back(b);
                        end
                    end
                    wr_idx = 0;
                end
            end
        end
    end

    // Output scoreboard: every presented bin must match the queue head, held until accepted.
    initial begin
        forever begin
            @(negedge clk);
            if (!reset && m_valid) begin
                if (exp_q.size() == 0) begin
                    fail("unexpected_bin");
                end else begin
                    chk("m_data",  64'(m_data),  64'(exp_q[0].data));
                    chk("m_mag2",  64'(m_mag2),  64'(exp_q[0].mag));
                    chk("m_index", 64'(m_index), 64'(exp_q[0].idx));
                    chk("m_last",  64'(m_last),  64'(exp_q[0].last));
                    if (m_ready) void'(exp_q.pop_front());
                end
            end
        end
    end

    initial begin
        m_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            m_ready = (rdy_mode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
        end
    end

    task automatic send_frame(input int kind, input bit gaps);
        logic [31:0] smp;
        bit acc;
        int guard;
        for (int i = 0; i < N; i++) begin
            case (kind)
                0:       smp = 32'(i) << 16;
                1:       smp = (i == 0) ? {16'd1000, 16'd0} : 32'd0;
                3:       smp = (i % 2 == 1) ? 32'h8000_8000 : $urandom;
                default: smp = $urandom;
            endcase
            acc = 1'b0;
            guard = 0;
            while (!acc) begin
                s_valid = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
                s_data  = smp;
                @(negedge clk);
                if (s_valid && s_ready) begin
                    acc = 1'b1;
                    acc_q.push_back(smp);
                end
                @(posedge clk);
                #1;
                guard++;
                if (guard > 20000) begin
                    fail("s_ready_timeout");
                    finish_now();
                end
            end
        end
        s_valid = 1'b0;
    endtask

    task automatic wait_drain();
        int guard = 0;
        while (busy || exp_q.size() != 0) begin
            @(negedge clk);
            guard++;
            if (guard > 20000) begin
                fail("drain_timeout");
                finish_now();
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic wait_start();
        int guard = 0;
        do begin
            @(negedge clk);
            guard++;
            if (guard > 1000) begin
                fail("start_timeout");
                finish_now();
            end
        end while (!start);
    endtask

    task automatic check_reset_values(input string tag);
        chk({tag, "_ctrl"}, 64'({s_ready, load, start, m_valid, m_last, err_tmo, busy}), 64'b1000000);
        chk({tag, "_addr"}, 64'({addr_wr, addr_rd, m_index}), 64'd0);
        chk({tag, "_mdata"}, {m_data, m_mag2}, 64'd0);
        chk({tag, "_indata"}, 64'(in_data), 64'd0);
    endtask

    initial begin
        int n;
        int guard;
        bit early;
        reset   = 1'b1;
        s_valid = 1'b0;
        s_data  = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_values("reset");
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(posedge clk);
        #1;

        // Ramp, continuous valid
        done_mode = 0; done_delay = 10; rdy_mode = 0;
        send_frame(0, 1'b0);
        wait_drain();

        // Impulse
        send_frame(1, 1'b0);
        wait_drain();

        // Random gaps and output back-pressure, plus the most negative sample corner
        rdy_mode = 1;
        for (int f = 0; f < 3; f++) begin
            done_delay = $urandom_range(1, 60);
            send_frame((f == 1) ? 3 : 2, 1'b1);
            wait_drain();
        end
        rdy_mode = 0;

        // Done level stuck high from the previous frame
        done_mode = 1;
        send_frame(2, 1'b0);
        wait_start();
        @(posedge clk);
        #1;
        early = 1'b0;
        guard = 0;
        while (!rise_flag && guard < 200) begin
            @(negedge clk);
            if (m_valid) early = 1'b1;
            guard++;
        end
        chk("stuck_done_no_early_readout", 64'(early), 64'd0);
        chk("stuck_done_rise_seen", 64'(rise_flag), 64'd1);
        wait_drain();

        // Done never comes
        done_mode = 2;
        send_frame(2, 1'b0);
        wait_start();
        n = 0;
        while (!err_tmo && n < TIMEOUT + 100) begin
            @(negedge clk);
            n++;
        end
        chk("tmo_latency_in_window", 64'(n >= TIMEOUT - 2 && n <= TIMEOUT + 2), 64'd1);
        chk("tmo_s_ready", 64'({s_ready, busy}), 64'b10);
        @(posedge clk);
        #1;
        done_mode = 0; done_delay = 7;
        send_frame(2, 1'b1);
        wait_drain();
        chk("err_tmo_sticky", 64'(err_tmo), 64'd1);

        // Reset while waiting on the read pipe for bin 7
        send_frame(2, 1'b0);
        guard = 0;
        while (!(addr_rd == LOG2N'(7) && !m_valid && busy)) begin
            @(negedge clk);
            guard++;
            if (guard > 2000) begin
                fail("reach_bin7_timeout");
                finish_now();
            end
        end
        @(negedge clk);
        #1;
        reset = 1'b1;
        #1;
        check_reset_values("midread_reset");
        exp_q.delete();
        acc_q.delete();
        wr_idx = 0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        @(posedge clk);
        #1;
        send_frame(3, 1'b1);
        wait_drain();

        finish_now();
    end

endmodule

`default_nettype wire
